conv_to_montgomery: RTL

//  Converts an operand from conventional to Montgomery representation: y = a * 2^NBITS mod m.

---
 rtl/conv_to_montgomery.sv | 84 ++++++++
 1 files changed

// File: rtl/conv_to_montgomery.sv
// Conventional-to-Montgomery converter: y = a * 2^NBITS mod m.
// Performs NBITS serial modular doublings, so no precomputed R^2 mod m is needed.
// The output uses the same R = 2^NBITS as the downstream Montgomery datapath.
module conv_to_montgomery #(
  parameter int unsigned NBITS = 2048
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable_p,
  input  logic [NBITS-1:0] a,
  input  logic [NBITS-1:0] m,
  output logic [NBITS-1:0] y,
  output logic             busy,
  output logic             done_irq_p
);

  localparam int unsigned CW = $clog2(NBITS + 1);
  localparam logic [CW-1:0] LastCnt = CW'(NBITS - 1);
  localparam logic [CW-1:0] CntOne  = CW'(1);

  typedef enum logic [0:0] {
    StIdle,
    StRun
  } state_e;

  state_e           state;
  logic [NBITS-1:0] acc;
  logic [NBITS-1:0] mreg;
  logic [CW-1:0]    cnt;

  logic [NBITS:0]   t;
  logic [NBITS:0]   mext;
  logic [NBITS-1:0] d;
  logic [NBITS-1:0] acc_next;

  // One modular doubling. The carry bit t[NBITS] takes part in the compare so that
  // moduli with the MSB set are handled; the difference fits in NBITS bits because
  // acc < m implies 2*acc - m < m.
  always_comb begin
    t        = {acc, 1'b0};
    mext     = {1'b0, mreg};
    d        = t[NBITS-1:0] - mreg;
    acc_next = (t >= mext) ? d : t[NBITS-1:0];
  end

  // Control FSM with registered outputs; y only changes together with the done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= StIdle;
      acc        <= '0;
      mreg       <= '0;
      cnt        <= '0;
      y          <= '0;
      busy       <= 1'b0;
      done_irq_p <= 1'b0;
    end else begin
      done_irq_p <= 1'b0;
      unique case (state)
        StIdle: begin
          if (enable_p) begin
            acc   <= a;
            mreg  <= m;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= StRun;
          end
        end
        StRun: begin
          acc <= acc_next;
          cnt <= cnt + CntOne;
          if (cnt == LastCnt) begin
            y          <= acc_next;
            done_irq_p <= 1'b1;
            busy       <= 1'b0;
            cnt        <= '0;
            state      <= StIdle;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule
